// File: rtl/lh_pp_meta_arb.sv
// Round-robin scheduler draining NUM_SRC FWFT metadata FIFOs into one registered
// stream toward the packet parser. Optional bursts to one source are capped at
// MAX_BURST grants; downstream flow control is credit based.
module lh_pp_meta_arb #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SRC_NBITS    = 2,
  parameter int unsigned CREDITS      = 8,
  parameter int unsigned CREDIT_NBITS = 4,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned BURST_NBITS  = 2,
  parameter int unsigned META_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_en,
  input  logic [NUM_SRC-1:0]        src_empty,
  input  logic [NUM_SRC*META_W-1:0] src_dout,
  output logic [NUM_SRC-1:0]        src_rd,
  output logic                      pp_valid,
  output logic [META_W-1:0]         pp_meta,
  output logic [SRC_NBITS-1:0]      pp_src,
  input  logic                      pp_credit,
  output logic [CREDIT_NBITS-1:0]   credit_cnt,
  output logic                      busy
);

  localparam logic [SRC_NBITS-1:0]    LastInit  = SRC_NBITS'(NUM_SRC - 1);
  localparam logic [BURST_NBITS-1:0]  BurstTop  = BURST_NBITS'(MAX_BURST - 1);
  localparam logic [CREDIT_NBITS-1:0] CreditMax = CREDIT_NBITS'(CREDITS);
  localparam logic                    BurstEn   = (MAX_BURST > 1);

  // Arbitration state
  logic [SRC_NBITS-1:0]    last_q, last_d;
  logic [BURST_NBITS-1:0]  bcnt_q, bcnt_d;
  logic                    bact_q, bact_d;
  logic [CREDIT_NBITS-1:0] credit_q, credit_d;

  // Output stage
  logic                    pp_valid_q;
  logic [META_W-1:0]       pp_meta_q, pp_meta_d;
  logic [SRC_NBITS-1:0]    pp_src_q;

  // Sticky diagnostic flags; never expected to set in a healthy system
  logic                    diag_credit_ovf_q;
  logic                    diag_rd_empty_q;
  logic                    diag_rd_onehot_q;

  logic [NUM_SRC-1:0]      elig;
  logic                    issue;
  logic                    stick;
  logic                    rot_found;
  logic [SRC_NBITS-1:0]    rot_grant;
  logic [SRC_NBITS-1:0]    cand;
  logic [SRC_NBITS-1:0]    grant;
  logic [NUM_SRC-1:0]      grant_oh;
  logic                    credit_ovf;
  logic                    rd_empty_err;
  logic                    rd_onehot_err;

  // Eligibility and issue: credits gate every pop, pp_credit only helps next cycle
  always_comb begin
    elig  = src_en & ~src_empty;
    issue = (|elig) & (credit_q != '0);
  end

  // Grant selection: stay on last while the burst has room, otherwise rotate
  always_comb begin
    // bcnt never exceeds BurstTop, so inequality means there is room left
    stick     = bact_q & elig[last_q] & (bcnt_q != BurstTop);
    rot_found = 1'b0;
    rot_grant = last_q;
    cand      = last_q;
    // Scan last+1 .. last+NUM_SRC; the final step revisits last itself
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_NBITS'((32'(last_q) + k) % NUM_SRC);
      if (!rot_found && elig[cand]) begin
        rot_found = 1'b1;
        rot_grant = cand;
      end
    end
    grant    = stick ? last_q : rot_grant;
    grant_oh = {{(NUM_SRC-1){1'b0}}, 1'b1} << grant;
    src_rd   = issue ? grant_oh : '0;
  end

  // Head-entry mux for the granted source
  always_comb begin
    pp_meta_d = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant == SRC_NBITS'(i)) begin
        pp_meta_d = src_dout[i*META_W +: META_W];
      end
    end
  end

  // Burst bookkeeping; any cycle without an issue ends the burst
  always_comb begin
    last_d = last_q;
    bcnt_d = bcnt_q;
    bact_d = 1'b0;
    if (issue) begin
      last_d = grant;
      if (stick) begin
        bcnt_d = bcnt_q + BURST_NBITS'(1);
        bact_d = 1'b1;
      end else begin
        bcnt_d = '0;
        bact_d = BurstEn;
      end
    end
  end

  // Credit counter: one spent per pop, one returned per pp_credit, saturating at CREDITS
  always_comb begin
    credit_d   = credit_q;
    credit_ovf = pp_credit & (credit_q == CreditMax);
    case ({issue, pp_credit})
      2'b10:   credit_d = credit_q - CREDIT_NBITS'(1);
      2'b01:   credit_d = (credit_q == CreditMax) ? credit_q : credit_q + CREDIT_NBITS'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Pop-sanity checks on the outgoing read strobes
  always_comb begin
    rd_empty_err  = |(src_rd & src_empty);
    rd_onehot_err = (src_rd & (src_rd - NUM_SRC'(1))) != '0;
  end

  // Arbitration and credit state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= LastInit;
      bcnt_q   <= '0;
      bact_q   <= 1'b0;
      credit_q <= CreditMax;
    end else begin
      last_q   <= last_d;
      bcnt_q   <= bcnt_d;
      bact_q   <= bact_d;
      credit_q <= credit_d;
    end
  end

  // Registered output stream; meta and src hold when nothing is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_valid_q <= 1'b0;
      pp_meta_q  <= '0;
      pp_src_q   <= '0;
    end else begin
      pp_valid_q <= issue;
      if (issue) begin
        pp_meta_q <= pp_meta_d;
        pp_src_q  <= grant;
      end
    end
  end

  // Sticky error flags for credit overflow and malformed pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diag_credit_ovf_q <= 1'b0;
      diag_rd_empty_q   <= 1'b0;
      diag_rd_onehot_q  <= 1'b0;
    end else begin
      diag_credit_ovf_q <= diag_credit_ovf_q | credit_ovf;
      diag_rd_empty_q   <= diag_rd_empty_q | rd_empty_err;
      diag_rd_onehot_q  <= diag_rd_onehot_q | rd_onehot_err;
    end
  end

  // Output drive
  always_comb begin
    pp_valid   = pp_valid_q;
    pp_meta    = pp_meta_q;
    pp_src     = pp_src_q;
    credit_cnt = credit_q;
    busy       = (|elig) | pp_valid_q;
  end

endmodule

// File: tb/tb_lh_pp_meta_arb.sv
// Directed bench for lh_pp_meta_arb. Three instances share the stimulus: a pure
// round-robin one (r), a default burst-4 one (m) and a two-credit one (c).
// Each scenario follows one instance's pops to evolve the FIFO model.
module tb_lh_pp_meta_arb;

  localparam int MW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [3:0]        src_en;
  logic [3:0]        src_empty;
  logic [4*MW-1:0]   src_dout;
  logic              pp_credit;

  int cnt[4];
  int popped[4];

  logic [3:0]    rd_r, rd_m, rd_c;
  logic          valid_r, valid_m, valid_c;
  logic [MW-1:0] meta_r, meta_m, meta_c;
  logic [1:0]    src_r, src_m, src_c;
  logic [4:0]    ccnt_r;
  logic [3:0]    ccnt_m;
  logic [1:0]    ccnt_c;
  logic          busy_r, busy_m, busy_c;

  int total = 0;
  int bad   = 0;

  // FIFO model: head entry encodes source id and how many entries were popped
  always_comb begin
    src_empty = '0;
    src_dout  = '0;
    for (int i = 0; i < 4; i++) begin
      src_empty[i]          = (cnt[i] == 0);
      src_dout[i*MW +: MW]  = {4'(i), 12'(popped[i])};
    end
  end

  lh_pp_meta_arb #(
    .NUM_SRC(4), .SRC_NBITS(2), .CREDITS(16), .CREDIT_NBITS(5),
    .MAX_BURST(1), .BURST_NBITS(2), .META_W(MW)
  ) u_r (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_empty(src_empty),
    .src_dout(src_dout), .src_rd(rd_r), .pp_valid(valid_r), .pp_meta(meta_r),
    .pp_src(src_r), .pp_credit(pp_credit), .credit_cnt(ccnt_r), .busy(busy_r)
  );

  lh_pp_meta_arb #(
    .NUM_SRC(4), .SRC_NBITS(2), .CREDITS(8), .CREDIT_NBITS(4),
    .MAX_BURST(4), .BURST_NBITS(2), .META_W(MW)
  ) u_m (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_empty(src_empty),
    .src_dout(src_dout), .src_rd(rd_m), .pp_valid(valid_m), .pp_meta(meta_m),
    .pp_src(src_m), .pp_credit(pp_credit), .credit_cnt(ccnt_m), .busy(busy_m)
  );

  lh_pp_meta_arb #(
    .NUM_SRC(4), .SRC_NBITS(2), .CREDITS(2), .CREDIT_NBITS(2),
    .MAX_BURST(4), .BURST_NBITS(2), .META_W(MW)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .src_en(src_en), .src_empty(src_empty),
    .src_dout(src_dout), .src_rd(rd_c), .pp_valid(valid_c), .pp_meta(meta_c),
    .pp_src(src_c), .pp_credit(pp_credit), .credit_cnt(ccnt_c), .busy(busy_c)
  );

  // Advance one clock, applying the given pops to the FIFO model after the edge
  task automatic step(input logic [3:0] rd);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        cnt[i]    = cnt[i] - 1;
        popped[i] = popped[i] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    pp_credit = 1'b0;
    src_en    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt[i]    = 0;
      popped[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (valid_m !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_m); end
    total++; if (meta_m !== '0) begin bad++; $display("FAIL rst_meta got=%h exp=0", meta_m); end
    total++; if (src_m !== 2'd0) begin bad++; $display("FAIL rst_src got=%0d exp=0", src_m); end
    total++; if (ccnt_m !== 4'd8) begin bad++; $display("FAIL rst_ccnt_m got=%0d exp=8", ccnt_m); end
    total++; if (ccnt_c !== 2'd2) begin bad++; $display("FAIL rst_ccnt_c got=%0d exp=2", ccnt_c); end
    total++; if (ccnt_r !== 5'd16) begin bad++; $display("FAIL rst_ccnt_r got=%0d exp=16", ccnt_r); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy_m); end
    total++; if (rd_m !== 4'b0000) begin bad++; $display("FAIL rst_rd got=%b exp=0000", rd_m); end
  endtask

  task automatic test_round_robin();
    logic [3:0]    exp_rd;
    logic [MW-1:0] exp_meta;
    do_reset();
    src_en = 4'b1111;
    for (int i = 0; i < 4; i++) cnt[i] = 3;
    for (int k = 0; k <= 12; k++) begin
      #1;
      exp_rd = (k < 12) ? (4'b0001 << (k % 4)) : 4'b0000;
      total++;
      if (rd_r !== exp_rd) begin
        bad++; $display("FAIL rr_rd cyc=%0d got=%b exp=%b", k, rd_r, exp_rd);
      end
      if (k == 0) begin
        total++;
        if (valid_r !== 1'b0 || busy_r !== 1'b1) begin
          bad++; $display("FAIL rr_first valid=%b busy=%b exp valid=0 busy=1", valid_r, busy_r);
        end
      end else begin
        exp_meta = {4'((k - 1) % 4), 12'((k - 1) / 4)};
        total++;
        if (valid_r !== 1'b1 || src_r !== 2'((k - 1) % 4) || meta_r !== exp_meta) begin
          bad++;
          $display("FAIL rr_out cyc=%0d valid=%b src=%0d meta=%h exp valid=1 src=%0d meta=%h",
                   k, valid_r, src_r, meta_r, (k - 1) % 4, exp_meta);
        end
      end
      step(rd_r);
    end
    #1;
    total++; if (valid_r !== 1'b0) begin bad++; $display("FAIL rr_drain_valid got=%b exp=0", valid_r); end
    total++; if (ccnt_r !== 5'd4) begin bad++; $display("FAIL rr_ccnt got=%0d exp=4", ccnt_r); end
  endtask

  task automatic test_burst();
    logic [1:0] seq [8];
    seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
    do_reset();
    src_en = 4'b1111;
    cnt[1] = 6;
    cnt[2] = 2;
    for (int k = 0; k < 8; k++) begin
      #1;
      total++;
      if (rd_m !== (4'b0001 << seq[k])) begin
        bad++; $display("FAIL burst_rd cyc=%0d got=%b exp_src=%0d", k, rd_m, seq[k]);
      end
      if (k > 0) begin
        total++;
        if (valid_m !== 1'b1 || src_m !== seq[k-1]) begin
          bad++; $display("FAIL burst_src cyc=%0d valid=%b src=%0d exp=%0d", k, valid_m, src_m,
                          seq[k-1]);
        end
      end
      step(rd_m);
    end
    #1;
    total++;
    if (valid_m !== 1'b1 || src_m !== 2'd1 || rd_m !== 4'b0000) begin
      bad++; $display("FAIL burst_last valid=%b src=%0d rd=%b exp 1/1/0000", valid_m, src_m, rd_m);
    end
    total++; if (ccnt_m !== 4'd0) begin bad++; $display("FAIL burst_ccnt got=%0d exp=0", ccnt_m); end
    step(rd_m);
    #1;
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL burst_idle_busy got=%b exp=0", busy_m); end
  endtask

  task automatic test_credit_stall();
    do_reset();
    src_en = 4'b1111;
    for (int i = 0; i < 4; i++) cnt[i] = 8;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (rd_c !== 4'b0001) begin bad++; $display("FAIL stall_pop cyc=%0d got=%b exp=0001", k, rd_c); end
      step(rd_c);
    end
    #1;
    total++;
    if (ccnt_c !== 2'd0 || rd_c !== 4'b0000) begin
      bad++; $display("FAIL stall_empty ccnt=%0d rd=%b exp 0/0000", ccnt_c, rd_c);
    end
    pp_credit = 1'b1;
    #1;
    total++; if (rd_c !== 4'b0000) begin bad++; $display("FAIL stall_credit_rd got=%b exp=0000", rd_c); end
    step(rd_c);
    pp_credit = 1'b0;
    #1;
    total++;
    if (ccnt_c !== 2'd1 || rd_c !== 4'b0010) begin
      bad++; $display("FAIL stall_resume ccnt=%0d rd=%b exp 1/0010", ccnt_c, rd_c);
    end
    step(rd_c);
    #1;
    total++;
    if (ccnt_c !== 2'd0 || valid_c !== 1'b1 || src_c !== 2'd1 || rd_c !== 4'b0000) begin
      bad++; $display("FAIL stall_after ccnt=%0d valid=%b src=%0d rd=%b exp 0/1/1/0000",
                      ccnt_c, valid_c, src_c, rd_c);
    end
  endtask

  task automatic test_credit_edges();
    do_reset();
    src_en = 4'b1111;
    cnt[0] = 4;
    #1;
    step(rd_c);
    #1;
    total++; if (ccnt_c !== 2'd1) begin bad++; $display("FAIL edge_pre ccnt=%0d exp=1", ccnt_c); end
    pp_credit = 1'b1;
    #1;
    total++; if (rd_c !== 4'b0001) begin bad++; $display("FAIL edge_issue rd=%b exp=0001", rd_c); end
    step(rd_c);
    pp_credit = 1'b0;
    #1;
    total++; if (ccnt_c !== 2'd1) begin bad++; $display("FAIL edge_simul ccnt=%0d exp=1", ccnt_c); end

    do_reset();
    #1;
    total++;
    if (u_m.diag_credit_ovf_q !== 1'b0) begin
      bad++; $display("FAIL ovf_clear flag=%b exp=0", u_m.diag_credit_ovf_q);
    end
    pp_credit = 1'b1;
    step(4'b0000);
    pp_credit = 1'b0;
    #1;
    total++; if (ccnt_m !== 4'd8) begin bad++; $display("FAIL ovf_sat ccnt=%0d exp=8", ccnt_m); end
    total++;
    if (u_m.diag_credit_ovf_q !== 1'b1) begin
      bad++; $display("FAIL ovf_flag flag=%b exp=1", u_m.diag_credit_ovf_q);
    end
  endtask

  task automatic test_src_mask();
    logic [3:0] exp_rd [4];
    exp_rd = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
    do_reset();
    src_en = 4'b1010;
    for (int i = 0; i < 4; i++) cnt[i] = 8;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) src_en = 4'b1000;
      #1;
      total++;
      if (rd_m !== exp_rd[k]) begin
        bad++; $display("FAIL mask_rd cyc=%0d got=%b exp=%b", k, rd_m, exp_rd[k]);
      end
      step(rd_m);
    end
    #1;
    total++;
    if (valid_m !== 1'b1 || src_m !== 2'd3 || ccnt_m !== 4'd4) begin
      bad++; $display("FAIL mask_end valid=%b src=%0d ccnt=%0d exp 1/3/4", valid_m, src_m, ccnt_m);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    src_en = 4'b1111;
    for (int i = 0; i < 4; i++) cnt[i] = 8;
    for (int k = 0; k < 5; k++) begin
      #1;
      step(rd_m);
    end
    #1;
    total++;
    if (valid_m !== 1'b1 || ccnt_m !== 4'd3 || src_m !== 2'd1) begin
      bad++; $display("FAIL mid_pre valid=%b ccnt=%0d src=%0d exp 1/3/1", valid_m, ccnt_m, src_m);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (valid_m !== 1'b0 || ccnt_m !== 4'd8 || src_m !== 2'd0) begin
      bad++; $display("FAIL mid_async valid=%b ccnt=%0d src=%0d exp 0/8/0", valid_m, ccnt_m, src_m);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (rd_m !== 4'b0001) begin bad++; $display("FAIL mid_first rd=%b exp=0001", rd_m); end
    step(rd_m);
    #1;
    total++;
    if (valid_m !== 1'b1 || src_m !== 2'd0 || meta_m !== {4'd0, 12'd4}) begin
      bad++; $display("FAIL mid_out valid=%b src=%0d meta=%h exp 1/0/0004", valid_m, src_m, meta_m);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    pp_credit = 1'b0;
    src_en    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt[i]    = 0;
      popped[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_burst();
    test_credit_stall();
    test_credit_edges();
    test_src_mask();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
